// File: rtl/if_queue.sv
// Instruction fetch queue: circular buffer of {pc, instr} pairs between fetch and decode.
// Flush discards everything in one edge; the head shows a NOP whenever nothing valid is queued.
module if_queue #(
    parameter int          DEPTH = 4,
    parameter logic [31:0] NOP   = 32'h00000013
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic                       out_misalign,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]   pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Flush gates both handshakes, so a flush edge never sees a push or pop.
    assign in_ready  = (count != CW'(DEPTH)) && !flush;
    assign out_valid = (count != '0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_pc       = out_valid ? pc_mem[rd_ptr]    : 32'h0;
    assign out_instr    = out_valid ? instr_mem[rd_ptr] : NOP;
    assign out_misalign = out_valid && (out_pc[1:0] != 2'b00);

    // NOTE: storage has no reset; validity comes only from count, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the modulo wrap.
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule
